sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Two-port arbiter for an asynchronous 16-bit SRAM: a video fetch port and a
// loader port. Video has priority, but the loader is guaranteed service after a bounded number of video grants.
`timescale 1ns/1ps
module sram_arbiter #(
  parameter int ACC_CYCLES   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        vid_req,
  input  logic [19:0] vid_addr,
  output logic [15:0] vid_rdata,
  output logic        vid_valid,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [1:0]  ld_be,
  input  logic [19:0] ld_addr,
  input  logic [15:0] ld_wdata,
  output logic        ld_gnt,
  output logic [15:0] ld_rdata,
  output logic        ld_done,
  output logic [19:0] SRAM_ADDR,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  input  logic [15:0] dq_in,
  output logic        busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VREAD  = 3'd1;
  localparam logic [2:0] S_LREAD  = 3'd2;
  localparam logic [2:0] S_LWRITE = 3'd3;
  localparam logic [2:0] S_TURN   = 3'd4;

  localparam logic [2:0] CYC_LAST   = 3'(ACC_CYCLES - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [2:0]  state_q, state_d;
  logic [2:0]  cyc_q, cyc_d;
  logic [3:0]  starve_q, starve_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] vid_rdata_q, vid_rdata_d;
  logic [15:0] ld_rdata_q, ld_rdata_d;
  logic        vid_valid_q, vid_valid_d;
  logic        ld_done_q, ld_done_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        ub_n_q, ub_n_d;
  logic        lb_n_q, lb_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic        busy_q, busy_d;
  logic        vid_gnt_s;
  logic        ld_gnt_s;
  logic        last_s;

  // Arbitration, transfer sequencing and read-data capture.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    starve_d    = starve_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    vid_rdata_d = vid_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    vid_valid_d = 1'b0;
    ld_done_d   = 1'b0;
    vid_gnt_s   = 1'b0;
    ld_gnt_s    = 1'b0;
    last_s      = (cyc_q == CYC_LAST);
    case (state_q)
      S_IDLE: begin
        cyc_d = 3'd0;
        if (ld_req && (starve_q == STARVE_MAX)) begin
          ld_gnt_s = 1'b1;
        end else if (vid_req) begin
          vid_gnt_s = 1'b1;
        end else if (ld_req) begin
          ld_gnt_s = 1'b1;
        end else begin
          ld_gnt_s = 1'b0;
        end
        if (ld_gnt_s) begin
          starve_d = 4'd0;
          addr_d   = ld_addr;
          wdata_d  = ld_wdata;
          be_d     = ld_be;
          state_d  = ld_we ? S_LWRITE : S_LREAD;
        end else if (vid_gnt_s) begin
          addr_d  = vid_addr;
          be_d    = 2'b11;
          state_d = S_VREAD;
          // Only video grants taken while the loader is waiting count toward starvation.
          if (!ld_req) begin
            starve_d = 4'd0;
          end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 4'd1;
          end else begin
            starve_d = starve_q;
          end
        end else begin
          starve_d = 4'd0;
        end
      end
      S_VREAD, S_LREAD: begin
        if (last_s) begin
          state_d = S_IDLE;
          cyc_d   = 3'd0;
          if (state_q == S_VREAD) begin
            vid_valid_d = 1'b1;
            vid_rdata_d = dq_in;
          end else begin
            ld_done_d  = 1'b1;
            ld_rdata_d = dq_in;
          end
        end else begin
          cyc_d = cyc_q + 3'd1;
        end
      end
      S_LWRITE: begin
        if (last_s) begin
          state_d   = S_TURN;
          cyc_d     = 3'd0;
          ld_done_d = 1'b1;
        end else begin
          cyc_d = cyc_q + 3'd1;
        end
      end
      S_TURN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // SRAM strobes decoded from the next state so they are flop outputs, glitch-free.
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    case (state_d)
      S_VREAD, S_LREAD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        ub_n_d = ~be_d[1];
        lb_n_d = ~be_d[0];
      end
      S_LWRITE: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        ub_n_d  = ~be_d[1];
        lb_n_d  = ~be_d[0];
        dq_oe_d = 1'b1;
      end
      default: begin
        ce_n_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      cyc_q       <= 3'd0;
      starve_q    <= 4'd0;
      addr_q      <= 20'd0;
      wdata_q     <= 16'd0;
      be_q        <= 2'b00;
      vid_rdata_q <= 16'd0;
      ld_rdata_q  <= 16'd0;
      vid_valid_q <= 1'b0;
      ld_done_q   <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      starve_q    <= starve_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      vid_rdata_q <= vid_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
      vid_valid_q <= vid_valid_d;
      ld_done_q   <= ld_done_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
      dq_oe_q     <= dq_oe_d;
      busy_q      <= busy_d;
    end
  end

  // The grant must be seen in the arbitration cycle itself, so it is the only combinational output.
  assign ld_gnt    = ld_gnt_s & Reset_n;
  assign vid_rdata = vid_rdata_q;
  assign vid_valid = vid_valid_q;
  assign ld_rdata  = ld_rdata_q;
  assign ld_done   = ld_done_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = ub_n_q;
  assign SRAM_LB_N = lb_n_q;
  assign dq_out    = wdata_q;
  assign dq_oe     = dq_oe_q;
  assign busy      = busy_q;

endmodule
